// File: rtl/serial_word_compare_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_compare_pkg
// Description : Shared types and constants for the nibble-serial magnitude
//               comparator: nibble width, scan state encoding, result record.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_word_compare_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic err;
    logic less;
    logic equal;
    logic greater;
  } result_t;

endpackage

`default_nettype wire

// File: rtl/serial_word_compare.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_compare
// Description : Multi-cycle magnitude comparator for W = 4*NIBBLES bit words.
//               Scans MS nibble first through an external 4-bit comparator,
//               stops at the first unequal nibble, returns a registered
//               less/equal/greater (or err) result over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_compare
  import serial_word_compare_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   in_b,
  output logic [NIBBLE_W-1:0]           cmp_a,
  output logic [NIBBLE_W-1:0]           cmp_b,
  input  logic                          cmp_less,
  input  logic                          cmp_equal,
  input  logic                          cmp_greater,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_less,
  output logic                          out_equal,
  output logic                          out_greater,
  output logic                          out_err
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [IDX_W-1:0]  r_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  result_t           r_result;

  logic              w_accept;
  logic              w_onehot;
  logic              w_last;
  logic              w_scan_exit;

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_onehot    = $onehot({cmp_less, cmp_equal, cmp_greater});
  assign w_last      = (r_idx == '0);
  // Any non-equal (or malformed) answer ends the scan; idx==0 ends it too.
  assign w_scan_exit = !w_onehot || !cmp_equal || w_last;

  // Nibble mux: present the nibble pair selected by idx to the comparator.
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        cmp_a = r_a[i*NIBBLE_W +: NIBBLE_W];
        cmp_b = r_b[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_next = SCAN;
      SCAN:    if (w_scan_exit) w_state_next = DONE;
      DONE:    if (out_ready)   w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, walk idx down, latch and clear the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_idx <= IDX_W'(NIBBLES - 1);
          end
        end
        SCAN: begin
          if (!w_onehot) begin
            r_result <= '{err: 1'b1, less: 1'b0, equal: 1'b0, greater: 1'b0};
          end else if (cmp_less) begin
            r_result <= '{err: 1'b0, less: 1'b1, equal: 1'b0, greater: 1'b0};
          end else if (cmp_greater) begin
            r_result <= '{err: 1'b0, less: 1'b0, equal: 1'b0, greater: 1'b1};
          end else if (w_last) begin
            r_result <= '{err: 1'b0, less: 1'b0, equal: 1'b1, greater: 1'b0};
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_result <= '0;
          end
        end
        default: begin
          r_result <= '0;
        end
      endcase
    end
  end

  // Output decode; in_ready is masked while reset is held.
  always_comb begin
    in_ready    = (r_state == IDLE) && !reset;
    out_valid   = (r_state == DONE);
    out_err     = r_result.err;
    out_less    = r_result.less;
    out_equal   = r_result.equal;
    out_greater = r_result.greater;
  end

endmodule

`default_nettype wire
